// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals of the UART TX arbiter.
// The arbiter connects through the slave modport. Requesters and the transmitter
// (or a bench) connect through the master modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        sent_done;
    logic                      tx_start_out;
    logic [DATA_W-1:0]         tx_data_out;
    logic                      tx_busy_in;
    logic                      tx_done_in;
    logic [ID_W-1:0]           active_id;
    logic                      arb_busy;

    modport master (
        output req, req_data, tx_busy_in, tx_done_in,
        input  grant, sent_done, tx_start_out, tx_data_out, active_id, arb_busy
    );

    modport slave (
        input  req, req_data, tx_busy_in, tx_done_in,
        output grant, sent_done, tx_start_out, tx_data_out, active_id, arb_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Transmitter busy/done come from the baud domain and are double-flopped here.
// Optional launch-to-completion watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.slave     bus
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_RUN      = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_sent_done;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic [ID_W-1:0]     r_active_id;
    logic                r_arb_busy;
    logic [ID_W-1:0]     r_last;

    logic r_busy_m, r_busy_s, r_busy_d;
    logic r_done_m, r_done_s, r_done_d;

    logic            w_win_valid;
    logic [ID_W-1:0] w_win_idx;
    logic            w_complete;
    logic            w_tmo_hit;

    // Index reached by stepping 'off' positions past 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
        end else begin
            j = j;
        end
        return ID_W'(j);
    endfunction

    // Two-flop synchronizers for busy/done plus one delay flop each for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_m <= 1'b0;
            r_busy_s <= 1'b0;
            r_busy_d <= 1'b0;
            r_done_m <= 1'b0;
            r_done_s <= 1'b0;
            r_done_d <= 1'b0;
        end else begin
            r_busy_m <= bus.tx_busy_in;
            r_busy_s <= r_busy_m;
            r_busy_d <= r_busy_s;
            r_done_m <= bus.tx_done_in;
            r_done_s <= r_done_m;
            r_done_d <= r_done_s;
        end
    end

    // Round-robin search: the smallest offset after the last owner wins, so scan far-to-near.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = {ID_W{1'b0}};
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.req[rr_idx(r_last, i)]) begin
                w_win_valid = 1'b1;
                w_win_idx   = rr_idx(r_last, i);
            end else begin
                w_win_valid = w_win_valid;
            end
        end
    end

    // A done rising edge or a busy falling edge ends the byte, whichever shows first.
    assign w_complete = (r_done_s & ~r_done_d) | (~r_busy_s & r_busy_d);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;
    logic             w_in_flight;

    assign w_in_flight = (r_state == S_LAUNCH) || (r_state == S_RUN);
    assign w_tmo_hit   = w_in_flight && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts while a byte is in flight, clears otherwise; error flag is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt     <= {TMO_W{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            if (w_in_flight && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= {TMO_W{1'b0}};
            end
            r_timeout_err <= r_timeout_err | w_tmo_hit;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Watchdog compiled out: never fires (parameter is still referenced so both builds share it).
    assign w_tmo_hit = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

    // Arbitration FSM with registered outputs; grant and sent_done default to zero for 1-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= {NUM_REQ{1'b0}};
            r_sent_done <= {NUM_REQ{1'b0}};
            r_tx_start  <= 1'b0;
            r_tx_data   <= {DATA_W{1'b0}};
            r_active_id <= {ID_W{1'b0}};
            r_arb_busy  <= 1'b0;
            r_last      <= ID_W'(NUM_REQ - 1);
        end else begin
            r_grant     <= {NUM_REQ{1'b0}};
            r_sent_done <= {NUM_REQ{1'b0}};
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                        r_tx_data   <= bus.req_data[int'(w_win_idx)*DATA_W +: DATA_W];
                        r_active_id <= w_win_idx;
                        r_last      <= w_win_idx;
                        r_tx_start  <= 1'b1;
                        r_arb_busy  <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end else begin
                        r_arb_busy  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (w_tmo_hit) begin
                        r_tx_start <= 1'b0;
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_busy_s) begin
                        r_tx_start <= 1'b0;
                        r_state    <= S_RUN;
                    end else begin
                        r_tx_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_tmo_hit) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_complete) begin
                        r_sent_done <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_active_id;
                        r_state     <= S_COMPLETE;
                    end else begin
                        r_state     <= S_RUN;
                    end
                end
                S_COMPLETE: begin
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.sent_done    = r_sent_done;
    assign bus.tx_start_out = r_tx_start;
    assign bus.tx_data_out  = r_tx_data;
    assign bus.active_id    = r_active_id;
    assign bus.arb_busy     = r_arb_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Define UART_TX_ARB_TIMEOUT_EN for both files to include the watchdog scenario.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TC = 50;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_grant = 0;
    int   n_sd = 0;

    // Transmitter model controls and observations.
    bit         m_enable    = 1'b1;
    bit         m_done_mode = 1'b0;
    bit         m_active    = 1'b0;
    int         m_busy_cyc  = 0;
    int         m_drop_cyc  = 0;
    logic [7:0] m_bytes[$];

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters: values seen here at a posedge are those of the preceding cycle.
    always @(posedge clk) begin
        if (bus.grant != 4'b0000) n_grant <= n_grant + 1;
        if (bus.sent_done != 4'b0000) n_sd <= n_sd + 1;
    end

    // Transmitter model: busy 3 clocks after start, held 100 clocks; optional done at busy fall.
    initial begin
        bus.tx_busy_in = 1'b0;
        bus.tx_done_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (m_enable && !m_active && bus.tx_start_out === 1'b1) begin
                m_active = 1'b1;
                m_bytes.push_back(bus.tx_data_out);
                repeat (3) @(posedge clk);
                #1 bus.tx_busy_in = 1'b1;
                m_busy_cyc = cyc;
                repeat (100) @(posedge clk);
                #1 bus.tx_busy_in = 1'b0;
                m_drop_cyc = cyc;
                if (m_done_mode) bus.tx_done_in = 1'b1;
                repeat (3) @(posedge clk);
                #1 bus.tx_done_in = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Waits (bounded) for a nonzero grant (which=0) or sent_done (which=1) and checks its value.
    task automatic wait_pulse(input string tag, input int which, input logic [3:0] exp, output int at);
        logic [3:0] seen;
        seen = 4'b0000;
        at = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (which == 0 && bus.grant != 4'b0000) begin seen = bus.grant; at = cyc; break; end
            if (which == 1 && bus.sent_done != 4'b0000) begin seen = bus.sent_done; at = cyc; break; end
        end
        chk(tag, {28'd0, seen}, {28'd0, exp});
    endtask

    // Waits (bounded) for tx_start_out to be low.
    task automatic wait_start_low(input string tag, output int at);
        logic got;
        got = 1'b0;
        at = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.tx_start_out === 1'b0) begin got = 1'b1; at = cyc; break; end
        end
        chk(tag, {31'd0, got}, 32'd1);
    endtask

    initial begin
        int t_g, t_s, t_f, t_g2, sd0;
        logic [3:0] exp_g [5];
        logic [7:0] exp_b [5];
        logic       idle_ok;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

        bus.req      = 4'b0000;
        bus.req_data = 32'h0000_0000;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outputs", {12'd0, bus.grant, bus.sent_done, bus.tx_start_out, bus.tx_data_out,
                              bus.active_id, bus.arb_busy}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Round robin with all four requesting; fresh pointer starts at requester 0.
        m_bytes.delete();
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        bus.req      = 4'b1111;
        sd0 = n_sd;
        for (int k = 0; k < 5; k++) begin
            wait_pulse("rr_grant", 0, exp_g[k], t_g);
            chk("rr_grant_after_done", sd0 + k, n_sd);
            chk("rr_data", {24'd0, bus.tx_data_out}, {24'd0, exp_b[k]});
            if (k == 4) bus.req = 4'b0000;
            wait_pulse("rr_done", 1, exp_g[k], t_s);
        end
        chk("rr_model_count", m_bytes.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < m_bytes.size()) chk("rr_model_byte", {24'd0, m_bytes[k]}, {24'd0, exp_b[k]});
        end

        // Single request with exact latencies.
        repeat (3) @(negedge clk);
        sd0 = n_sd;
        bus.req_data[7:0] = 8'hA5;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("single_grant_latency", {28'd0, bus.grant}, 32'h1);
        chk("single_start", {31'd0, bus.tx_start_out}, 32'd1);
        chk("single_data", {24'd0, bus.tx_data_out}, 32'hA5);
        chk("single_arb_busy", {31'd0, bus.arb_busy}, 32'd1);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("single_grant_one_pulse", {28'd0, bus.grant}, 32'h0);
        wait_start_low("single_start_fall", t_f);
        chk("single_start_fall_lat", t_f - m_busy_cyc, 32'd3);
        chk("single_data_stable", {24'd0, bus.tx_data_out}, 32'hA5);
        wait_pulse("single_done", 1, 4'b0001, t_s);
        chk("single_done_lat", t_s - m_drop_cyc, 32'd3);
        repeat (5) @(negedge clk);
        chk("single_done_count", n_sd - sd0, 32'd1);
        chk("single_idle", {31'd0, bus.arb_busy}, 32'd0);
        chk("single_model_byte", {24'd0, m_bytes[m_bytes.size()-1]}, 32'hA5);

        // Pointer wrap: requester 3 goes last, then 1001 serves 0 before 3.
        bus.req = 4'b1000;
        wait_pulse("wrap_g3", 0, 4'b1000, t_g);
        bus.req = 4'b0000;
        wait_pulse("wrap_d3", 1, 4'b1000, t_s);
        repeat (3) @(negedge clk);
        bus.req = 4'b1001;
        wait_pulse("wrap_first", 0, 4'b0001, t_g);
        chk("wrap_first_id", {30'd0, bus.active_id}, 32'd0);
        wait_pulse("wrap_first_done", 1, 4'b0001, t_s);
        wait_pulse("wrap_second", 0, 4'b1000, t_g);
        chk("wrap_second_id", {30'd0, bus.active_id}, 32'd3);
        bus.req = 4'b0000;
        wait_pulse("wrap_second_done", 1, 4'b1000, t_s);

        // Done rise and busy fall in the same cycle.
        repeat (3) @(negedge clk);
        m_done_mode = 1'b1;
        sd0 = n_sd;
        bus.req = 4'b0010;
        wait_pulse("both_grant", 0, 4'b0010, t_g);
        wait_pulse("both_done", 1, 4'b0010, t_s);
        wait_pulse("both_regrant", 0, 4'b0010, t_g2);
        chk("both_regrant_not_early", t_g2 - t_s, 32'd2);
        chk("both_single_done", n_sd - sd0, 32'd1);
        bus.req = 4'b0000;
        wait_pulse("both_done2", 1, 4'b0010, t_s);
        repeat (6) @(negedge clk);
        chk("both_done_count", n_sd - sd0, 32'd2);
        m_done_mode = 1'b0;

        // Reset while RUN.
        repeat (3) @(negedge clk);
        sd0 = n_sd;
        bus.req = 4'b0001;
        wait_pulse("rst_grant", 0, 4'b0001, t_g);
        bus.req = 4'b0000;
        wait_start_low("rst_in_run", t_f);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_outputs_now", {12'd0, bus.grant, bus.sent_done, bus.tx_start_out, bus.tx_data_out,
                                bus.active_id, bus.arb_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!m_active) begin idle_ok = 1'b1; break; end
        end
        chk("rst_model_idle", {31'd0, idle_ok}, 32'd1);
        repeat (5) @(negedge clk);
        chk("rst_no_done", n_sd - sd0, 32'd0);
        bus.req_data[23:16] = 8'h5C;
        bus.req = 4'b0100;
        wait_pulse("rst_regrant", 0, 4'b0100, t_g);
        chk("rst_regrant_data", {24'd0, bus.tx_data_out}, 32'h5C);
        chk("rst_regrant_id", {30'd0, bus.active_id}, 32'd2);
        bus.req = 4'b0000;
        wait_pulse("rst_regrant_done", 1, 4'b0100, t_s);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog: transmitter never answers.
        repeat (3) @(negedge clk);
        chk("tmo_err_clear", {31'd0, timeout_err}, 32'd0);
        m_enable = 1'b0;
        sd0 = n_sd;
        bus.req = 4'b0001;
        wait_pulse("tmo_grant", 0, 4'b0001, t_g);
        bus.req = 4'b0000;
        wait_start_low("tmo_start_drop", t_f);
        chk("tmo_start_drop_cycle", t_f - t_g, TC);
        chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
        chk("tmo_back_idle", {31'd0, bus.arb_busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("tmo_no_done", n_sd - sd0, 32'd0);
        m_enable = 1'b1;
        bus.req = 4'b0010;
        wait_pulse("tmo_next_grant", 0, 4'b0010, t_g);
        bus.req = 4'b0000;
        wait_pulse("tmo_next_done", 1, 4'b0010, t_s);
        chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
